// File: rtl/qr_scan_pkg.sv
// Shared types and ratio test for the finder-pattern scanners.
// Imported by the ratio scanner and the horizontal locator.
package qr_scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_EMIT,
    S_DONE
  } scan_state_t;

  localparam int WIN = 5;
  localparam int CALC_W = 32;

  localparam logic [WIN-1:0][2:0] RATIO_K = {
    3'd1, 3'd1, 3'd3, 3'd1, 3'd1
  };

  // One window slot against its 1:1:3:1:1 share of the window sum.
  function automatic logic ratio_ok(
    input logic [CALC_W-1:0] run,
    input logic [2:0]        k,
    input logic [CALC_W-1:0] s,
    input int unsigned       tol_shift
  );
    logic [CALC_W-1:0] a;
    logic [CALC_W-1:0] b;
    logic [CALC_W-1:0] d;
    a = run * CALC_W'(7);
    b = s * CALC_W'(k);
    d = (a >= b) ? (a - b) : (b - a);
    return d <= (s >> tol_shift);
  endfunction

endpackage

// File: rtl/run_length_encoder.sv
// Run-length encoder for one scan line of binarised pixels.
// A run is reported on a colour change and once more after the last pixel.
module run_length_encoder #(
  parameter int LEN_W = 10,
  parameter int POS_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             pixel,
  input  logic             valid,
  input  logic             last,
  output logic [LEN_W-1:0] run_len,
  output logic             run_colour,
  output logic [POS_W-1:0] run_start,
  output logic             run_valid
);

  logic [LEN_W-1:0] len_q;
  logic             colour_q;
  logic [POS_W-1:0] start_q;
  logic [POS_W-1:0] pos_q;
  logic             open_q;
  logic             flush_q;
  logic             change;

  assign change = valid && open_q
               && (pixel != colour_q);
  assign run_valid  = change || flush_q;
  assign run_len    = len_q;
  assign run_colour = colour_q;
  assign run_start  = start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= '0;
      colour_q <= 1'b0;
      start_q  <= '0;
      pos_q    <= '0;
      open_q   <= 1'b0;
      flush_q  <= 1'b0;
    end else if (clear) begin
      len_q    <= '0;
      colour_q <= 1'b0;
      start_q  <= '0;
      pos_q    <= '0;
      open_q   <= 1'b0;
      flush_q  <= 1'b0;
    end else begin
      // The run holding the last pixel is closed one cycle later.
      flush_q <= valid && last;
      if (flush_q) begin
        open_q <= 1'b0;
      end
      if (valid) begin
        pos_q <= pos_q + POS_W'(1);
        if (!open_q || change) begin
          open_q   <= 1'b1;
          colour_q <= pixel;
          len_q    <= LEN_W'(1);
          start_q  <= pos_q;
        end else begin
          len_q <= len_q + LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/finder_ratio_scanner.sv
// Scans rows or columns of a binarised frame for 1:1:3:1:1 runs.
// Emits one record per line: match count and first match centre.
module finder_ratio_scanner
  import qr_scan_pkg::*;
#(
  parameter int   WIDTH        = 640,
  parameter int   HEIGHT       = 480,
  parameter int   READ_LATENCY = 2,
  parameter int   TOL_SHIFT    = 1,
  parameter logic BLACK_VALUE  = 1'b0,
  parameter int   CNT_W        = 4,
  localparam int  MAX_DIM = (WIDTH > HEIGHT) ? WIDTH : HEIGHT,
  localparam int  ADDR_W  = $clog2(WIDTH * HEIGHT),
  localparam int  IDX_W   = $clog2(MAX_DIM),
  localparam int  RUN_W   = $clog2(MAX_DIM + 1),
  localparam int  SUM_W   = RUN_W + 3
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic              dir_in,
  output logic [ADDR_W-1:0] pixel_address,
  input  logic              pixel_data,
  output logic              busy_out,
  output logic              line_valid_out,
  input  logic              line_ready_in,
  output logic [IDX_W-1:0]  line_index_out,
  output logic [CNT_W-1:0]  match_count_out,
  output logic [IDX_W-1:0]  first_center_out,
  output logic              done_out
);

  scan_state_t state_q;
  scan_state_t state_d;

  logic             dir_q;
  logic [IDX_W-1:0] line_q;
  logic [IDX_W-1:0] pos_q;
  logic [2:0]       drain_q;
  logic             issue;
  logic             line_start;
  logic [IDX_W-1:0] len_last;
  logic [IDX_W-1:0] lines_last;

  logic [READ_LATENCY-1:0] tag_q;
  logic [READ_LATENCY-1:0] last_q;

  logic [RUN_W-1:0] run_len;
  logic             run_colour;
  logic [IDX_W-1:0] run_start;
  logic             run_valid;
  logic             run_black;

  logic [WIN-2:0][RUN_W-1:0] win_len_q;
  logic [WIN-2:0]            win_black_q;
  logic [IDX_W-1:0]          start2_q;
  logic [IDX_W-1:0]          start3_q;
  logic [2:0]                fill_q;
  logic [WIN-1:0][RUN_W-1:0] cand_len;
  logic [WIN-1:0]            cand_black;
  logic [SUM_W-1:0]          sum;
  logic                      ratios_ok;
  logic                      match;
  logic [IDX_W-1:0]          center_calc;

  logic [CNT_W-1:0] count_q;
  logic [IDX_W-1:0] center_q;
  logic             found_q;

  assign len_last = dir_q ? IDX_W'(HEIGHT - 1)
                          : IDX_W'(WIDTH - 1);
  assign lines_last = dir_q ? IDX_W'(WIDTH - 1)
                            : IDX_W'(HEIGHT - 1);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    line_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_in) begin
          state_d    = S_FETCH;
          line_start = 1'b1;
        end
      end
      S_FETCH: begin
        issue = 1'b1;
        if (pos_q == len_last) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_q == 3'(READ_LATENCY)) begin
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (line_ready_in) begin
          if (line_q == lines_last) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_FETCH;
            line_start = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    pixel_address = '0;
    if (issue) begin
      if (dir_q) begin
        pixel_address = ADDR_W'(line_q)
          + ADDR_W'(pos_q) * ADDR_W'(WIDTH);
      end else begin
        pixel_address = ADDR_W'(pos_q)
          + ADDR_W'(line_q) * ADDR_W'(WIDTH);
      end
    end
  end

  assign busy_out = (state_q == S_FETCH)
                 || (state_q == S_DRAIN)
                 || (state_q == S_EMIT);
  assign line_valid_out   = (state_q == S_EMIT);
  assign done_out         = (state_q == S_DONE);
  assign line_index_out   = line_q;
  assign match_count_out  = count_q;
  assign first_center_out = center_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      dir_q   <= 1'b0;
      line_q  <= '0;
      pos_q   <= '0;
      drain_q <= '0;
    end else begin
      if (state_q == S_IDLE && start_in) begin
        dir_q  <= dir_in;
        line_q <= '0;
      end else if (state_q == S_EMIT && line_start) begin
        line_q <= line_q + IDX_W'(1);
      end
      if (line_start) begin
        pos_q <= '0;
      end else if (issue) begin
        pos_q <= pos_q + IDX_W'(1);
      end
      drain_q <= (state_q == S_DRAIN)
               ? drain_q + 3'd1 : 3'd0;
    end
  end

  // Address tags ride alongside the memory read latency.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tag_q  <= '0;
      last_q <= '0;
    end else begin
      tag_q[0]  <= issue;
      last_q[0] <= issue && (pos_q == len_last);
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_q[i]  <= tag_q[i-1];
        last_q[i] <= last_q[i-1];
      end
    end
  end

  run_length_encoder #(
    .LEN_W (RUN_W),
    .POS_W (IDX_W)
  ) u_rle (
    .clk        (clk_in),
    .rst_n      (rst_n_in),
    .clear      (line_start),
    .pixel      (pixel_data),
    .valid      (tag_q[READ_LATENCY-1]),
    .last       (last_q[READ_LATENCY-1]),
    .run_len    (run_len),
    .run_colour (run_colour),
    .run_start  (run_start),
    .run_valid  (run_valid)
  );

  assign run_black  = (run_colour == BLACK_VALUE);
  assign cand_len   = {run_len, win_len_q};
  assign cand_black = {run_black, win_black_q};

  always_comb begin
    sum       = '0;
    ratios_ok = 1'b1;
    for (int i = 0; i < WIN; i++) begin
      sum = sum + SUM_W'(cand_len[i]);
    end
    for (int i = 0; i < WIN; i++) begin
      ratios_ok = ratios_ok & ratio_ok(
        CALC_W'(cand_len[i]), RATIO_K[i],
        CALC_W'(sum), TOL_SHIFT);
    end
  end

  assign match = run_valid && (fill_q == 3'd4)
              && cand_black[0] && ratios_ok;
  assign center_calc = start2_q
    + IDX_W'(win_len_q[2] >> 1);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      win_len_q   <= '0;
      win_black_q <= '0;
      start2_q    <= '0;
      start3_q    <= '0;
      fill_q      <= '0;
      count_q     <= '0;
      center_q    <= '0;
      found_q     <= 1'b0;
    end else if (line_start) begin
      win_len_q   <= '0;
      win_black_q <= '0;
      start2_q    <= '0;
      start3_q    <= '0;
      fill_q      <= '0;
      count_q     <= '0;
      center_q    <= '0;
      found_q     <= 1'b0;
    end else if (run_valid) begin
      // Slide by one run regardless of the match result.
      win_len_q   <= cand_len[WIN-1:1];
      win_black_q <= cand_black[WIN-1:1];
      start3_q    <= run_start;
      start2_q    <= start3_q;
      if (fill_q != 3'd4) begin
        fill_q <= fill_q + 3'd1;
      end
      if (match) begin
        if (count_q != '1) begin
          count_q <= count_q + CNT_W'(1);
        end
        if (!found_q) begin
          center_q <= center_calc;
          found_q  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_finder_ratio_scanner.sv
// Scoreboard bench: a 32x4 row scanner and an 8x16 column scanner.
// Expected records are queued at stimulus time and checked on handshake.
module tb_finder_ratio_scanner;

  localparam int AW = 32;
  localparam int AH = 4;
  localparam int AL = 2;
  localparam int BW = 8;
  localparam int BH = 16;
  localparam int BL = 3;

  typedef struct {
    int line;
    int count;
    int center;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int done_a_cnt = 0;
  int done_b_cnt = 0;
  rec_t q_a[$];
  rec_t q_b[$];
  rec_t ra;
  rec_t rb;

  logic       rst_a, start_a, dir_a, ready_a;
  logic       busy_a, valid_a, done_a;
  logic [6:0] addr_a;
  logic [4:0] line_a, center_a;
  logic [3:0] count_a;
  logic       mem_a [AW*AH];
  logic [AL-1:0] pipe_a = '0;

  logic       rst_b, start_b, dir_b, ready_b;
  logic       busy_b, valid_b, done_b;
  logic [6:0] addr_b;
  logic [3:0] line_b, center_b;
  logic [3:0] count_b;
  logic       mem_b [BW*BH];
  logic [BL-1:0] pipe_b = '0;

  always @(posedge clk) pipe_a <= {pipe_a[AL-2:0], mem_a[addr_a]};
  always @(posedge clk) pipe_b <= {pipe_b[BL-2:0], mem_b[addr_b]};

  finder_ratio_scanner #(
    .WIDTH(AW), .HEIGHT(AH), .READ_LATENCY(AL)
  ) dut_a (
    .clk_in(clk), .rst_n_in(rst_a),
    .start_in(start_a), .dir_in(dir_a),
    .pixel_address(addr_a), .pixel_data(pipe_a[AL-1]),
    .busy_out(busy_a), .line_valid_out(valid_a),
    .line_ready_in(ready_a), .line_index_out(line_a),
    .match_count_out(count_a), .first_center_out(center_a),
    .done_out(done_a)
  );

  finder_ratio_scanner #(
    .WIDTH(BW), .HEIGHT(BH), .READ_LATENCY(BL)
  ) dut_b (
    .clk_in(clk), .rst_n_in(rst_b),
    .start_in(start_b), .dir_in(dir_b),
    .pixel_address(addr_b), .pixel_data(pipe_b[BL-1]),
    .busy_out(busy_b), .line_valid_out(valid_b),
    .line_ready_in(ready_b), .line_index_out(line_b),
    .match_count_out(count_b), .first_center_out(center_b),
    .done_out(done_b)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic push(input int which, input int l, input int c, input int ctr);
    rec_t r;
    r.line = l;
    r.count = c;
    r.center = ctr;
    if (which == 0) q_a.push_back(r);
    else q_b.push_back(r);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_row_a(input int row, input string s);
    for (int i = 0; i < AW; i++)
      mem_a[row*AW+i] = (i < s.len() && s[i] == "b") ? 1'b0 : 1'b1;
  endtask

  task automatic set_col_b(input int col, input string s);
    for (int i = 0; i < BH; i++)
      mem_b[col+i*BW] = (i < s.len() && s[i] == "b") ? 1'b0 : 1'b1;
  endtask

  task automatic start_scan_a(input logic d);
    @(posedge clk);
    #1 dir_a = d;
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
  endtask

  task automatic start_scan_b(input logic d);
    @(posedge clk);
    #1 dir_b = d;
    start_b = 1'b1;
    step(1);
    start_b = 1'b0;
  endtask

  task automatic wait_done_a(input int target, input int budget);
    int n = 0;
    while (done_a_cnt < target && n < budget) begin
      step(1);
      n++;
    end
    check("a done pulses", done_a_cnt, target);
  endtask

  task automatic wait_done_b(input int target, input int budget);
    int n = 0;
    while (done_b_cnt < target && n < budget) begin
      step(1);
      n++;
    end
    check("b done pulses", done_b_cnt, target);
  endtask

  always @(negedge clk) begin
    if (rst_a === 1'b1 && valid_a === 1'b1 && ready_a === 1'b1) begin
      check("a record expected", int'(q_a.size() > 0), 1);
      if (q_a.size() > 0) begin
        ra = q_a.pop_front();
        check("a line_index", int'(line_a), ra.line);
        check("a match_count", int'(count_a), ra.count);
        check("a first_center", int'(center_a), ra.center);
      end
    end
    if (done_a === 1'b1) begin
      check("a done after all records", q_a.size(), 0);
      done_a_cnt++;
    end
  end

  always @(negedge clk) begin
    if (rst_b === 1'b1 && valid_b === 1'b1 && ready_b === 1'b1) begin
      check("b record expected", int'(q_b.size() > 0), 1);
      if (q_b.size() > 0) begin
        rb = q_b.pop_front();
        check("b line_index", int'(line_b), rb.line);
        check("b match_count", int'(count_b), rb.count);
        check("b first_center", int'(center_b), rb.center);
      end
    end
    if (done_b === 1'b1) begin
      check("b done after all records", q_b.size(), 0);
      done_b_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  initial begin
    int n;
    logic [6:0] addr_hold;
    rst_a = 1'b0;
    rst_b = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    dir_a = 1'b0;
    dir_b = 1'b0;
    ready_a = 1'b1;
    ready_b = 1'b1;
    for (int i = 0; i < AW*AH; i++) mem_a[i] = 1'b1;
    for (int i = 0; i < BW*BH; i++) mem_b[i] = 1'b1;
    step(3);
    check("a reset outputs", int'({busy_a, valid_a, done_a, addr_a,
          line_a, count_a, center_a}), 0);
    check("b reset outputs", int'({busy_b, valid_b, done_b, addr_b,
          line_b, count_b, center_b}), 0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    step(2);

    // Basic pattern on row 0, blank rows after it.
    set_row_a(0, "wwbbwwbbbbbbwwbb");
    push(0, 0, 1, 9);
    push(0, 1, 0, 0);
    push(0, 2, 0, 0);
    push(0, 3, 0, 0);
    start_scan_a(1'b0);
    check("a busy after start", int'(busy_a), 1);
    wait_done_a(1, 400);

    // Tolerance edges, overlapping patterns, back-pressure on line 0.
    set_row_a(0, "wwbbwwbbbbbbwwbbb");
    set_row_a(1, "wwbbwwbbbbbbwwbbbb");
    set_row_a(2, "wwwwbwbbbwbwbbbwb");
    set_row_a(3, "");
    push(0, 0, 1, 9);
    push(0, 1, 0, 0);
    push(0, 2, 2, 7);
    push(0, 3, 0, 0);
    ready_a = 1'b0;
    start_scan_a(1'b0);
    n = 0;
    while (valid_a !== 1'b1 && n < 200) begin
      step(1);
      n++;
    end
    check("a first record valid", int'(valid_a), 1);
    addr_hold = addr_a;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("a stalled valid", int'(valid_a), 1);
      check("a stalled record", int'({line_a, count_a, center_a}),
            int'({5'd0, 4'd1, 5'd9}));
      check("a stalled address", int'(addr_a), int'(addr_hold));
    end
    ready_a = 1'b1;
    step(1);
    check("a fetch right after release", int'(addr_a), 1 * AW);
    wait_done_a(2, 400);

    // Reset in the middle of line 2 abandons the scan.
    push(0, 0, 1, 9);
    push(0, 1, 0, 0);
    start_scan_a(1'b0);
    n = 0;
    while (q_a.size() > 0 && n < 300) begin
      step(1);
      n++;
    end
    check("a lines 0-1 accepted", q_a.size(), 0);
    step(5);
    check("a on line 2", int'(line_a), 2);
    check("a busy mid line", int'(busy_a), 1);
    rst_a = 1'b0;
    #1;
    check("a async reset outputs", int'({busy_a, valid_a, done_a, addr_a,
          line_a, count_a, center_a}), 0);
    step(1);
    rst_a = 1'b1;
    step(2);

    // Fresh scan from line 0; a second start while busy is ignored.
    push(0, 0, 1, 9);
    push(0, 1, 0, 0);
    push(0, 2, 2, 7);
    push(0, 3, 0, 0);
    start_scan_a(1'b0);
    step(10);
    dir_a = 1'b1;
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    wait_done_a(3, 400);

    // Column scan with a pattern starting at pixel 0.
    set_col_b(3, "wbwbbbwb");
    set_col_b(5, "bbwwbbbbbbwwbbww");
    for (int c = 0; c < BW; c++) begin
      if (c == 3) push(1, c, 1, 4);
      else if (c == 5) push(1, c, 1, 7);
      else push(1, c, 0, 0);
    end
    start_scan_b(1'b1);
    for (int l = 0; l < 2; l++) begin
      for (int p = 0; p < BH; p++) begin
        check($sformatf("b address line %0d pos %0d", l, p),
              int'(addr_b), l + p * BW);
        step(1);
      end
      if (l == 0) step(BL + 2);
    end
    wait_done_b(1, 400);

    step(5);
    check("a total done pulses", done_a_cnt, 3);
    check("b total done pulses", done_b_cnt, 1);
    check("a leftover records", q_a.size(), 0);
    check("b leftover records", q_b.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/finder_ratio_scanner.md
Name: finder_ratio_scanner

Overview:
Parametrised successor to the single-direction finder-ratio scanner. Streams one line (row or column, selected per run) of a binarised frame buffer through a run-length encoder and a sliding 5-run 1:1:3:1:1 checker. Emits one result record per line over a valid/ready handshake: match count and first-match centre. Sits between the binarised frame BRAM and the finder-pattern locator.

Parameters:
WIDTH, 640, frame width in pixels
HEIGHT, 480, frame height in pixels
READ_LATENCY, 2, cycles from pixel_address to pixel_data (1..4)
TOL_SHIFT, 1, tolerance = S >> TOL_SHIFT, where S is the sum of the 5 window runs
BLACK_VALUE, 0, pixel_data value that denotes black
CNT_W, 4, match_count width; saturating

Ports:
clk_in  in  1  clock
rst_n_in  in  1  asynchronous active-low reset
start_in  in  1  one-cycle start pulse; ignored unless IDLE
dir_in  in  1  0 = horizontal rows, 1 = vertical columns; sampled on accepted start
pixel_address  out  $clog2(WIDTH*HEIGHT)  frame buffer read address
pixel_data  in  1  binarised pixel, READ_LATENCY cycles after address
busy_out  out  1  high from accepted start until done
line_valid_out  out  1  result record valid
line_ready_in  in  1  consumer accepts record
line_index_out  out  $clog2(max(WIDTH,HEIGHT))  row or column number
match_count_out  out  CNT_W  patterns found in line
first_center_out  out  $clog2(max(WIDTH,HEIGHT))  centre of first match; 0 when count is 0
done_out  out  1  one-cycle pulse after last record accepted

Behaviour:
- Asynchronous active-low reset; one clock. Reset values: all outputs 0; FSM IDLE; run window cleared. Reset mid-line abandons the line with no record.
- LINE_LEN = dir ? HEIGHT : WIDTH. NUM_LINES = dir ? WIDTH : HEIGHT.
- Address: horizontal = pos + line*WIDTH; vertical = line + pos*WIDTH.
- FSM states: IDLE, FETCH, DRAIN, EMIT, DONE.
  - IDLE -> FETCH on start_in. Clears line = 0.
  - FETCH: issues one address per cycle, pos 0..LINE_LEN-1. A valid tag is delayed READ_LATENCY to qualify pixel_data. After pos LINE_LEN-1 -> DRAIN.
  - DRAIN: READ_LATENCY+1 cycles to retire the pipeline and close the final run. -> EMIT.
  - EMIT: line_valid_out high; record fields stable until line_ready_in. On handshake: if line == NUM_LINES-1 -> DONE, else line+1, clear per-line state, -> FETCH.
  - DONE: done_out=1 for one cycle, busy_out=0 -> IDLE.
- Minimum line period = LINE_LEN + READ_LATENCY + 2 cycles. No address is issued while in EMIT, so back-pressure stalls fetch.
- Run encoder:
  - A run closes on a colour change or at line end. The line end always closes the open run.
  - Run length width RUN_W = $clog2(max(WIDTH,HEIGHT)+1). Start position is recorded per run.
- Checker: on each closed run, shift it into a 5-entry window.
  - Evaluate only when the window is full and the oldest run is black.
  - Compute S = r0+...+r4, width RUN_W+3.
  - Match iff for each i, |7*r_i - k_i*S| <= (S >> TOL_SHIFT), with k = {1,1,3,1,1}. Products use width RUN_W+6, unsigned with explicit abs.
  - On match: match_count saturates at 2^CNT_W-1. If this is the first match, first_center = start(r2) + (r2 >> 1).
  - The window slides by one run and does not reset on a mismatch, so overlapping patterns are both found.
- Window, count and centre clear at the start of every line.

Decomposition:
- Package qr_scan_pkg holds:
  - the scan_state enum;
  - the ratio weights k as a localparam array;
  - the function ratio_ok(run, k, S, tol_shift) returning the match bit.
- Sub-module run_length_encoder: pixel/valid/last in, run length, colour, start position and run_valid out. Reused by the horizontal locator.

Test Plan:
1. WIDTH=32, HEIGHT=4, dir=0; row 0 = white 2, b2 w2 b6 w2 b2, rest white -> record line 0: count=1, centre=9. Rows 1-3 all white -> count=0, centre=0. done_out pulses once after the 4th handshake.
2. Tolerance edge, row = b2 w2 b6 w2 b3 -> count=1 (S=15, |21-15|=6 <= 7). Row = b2 w2 b6 w2 b4 -> count=0 (|28-16|=12 > 8).
3. Overlap, row = white 4, b1 w1 b3 w1 b1 w1 b3 w1 b1 -> count=2, centre=7.
4. Back-pressure: hold line_ready_in=0 for 10 cycles in EMIT -> line_valid_out stays high, fields constant, pixel_address frozen. Release -> next line starts fetching the following cycle.
5. Vertical: WIDTH=8, HEIGHT=16, dir=1, READ_LATENCY=3 -> addresses line + pos*8; 8 records, line_index 0..7; 16 addresses per line.
6. Reset: assert rst_n_in low mid-FETCH of line 2 -> all outputs 0 immediately. Ignore start_in while busy. A new start rescans from line 0.
